// File: rtl/rename_alloc_ctrl_pkg.sv
// Shared rename-allocation types: FSM encoding and architectural register constants.
package rename_alloc_ctrl_pkg;

  localparam int ARCH_REGS  = 32;
  localparam int VREG_WIDTH = 5;

  typedef enum logic [0:0] {
    RN_RUN     = 1'b0,
    RN_RECOVER = 1'b1
  } rn_state_e;

endpackage

// File: rtl/rename_alloc_ctrl_free_fifo.sv
// Circular free list of physical registers. It comes out of reset holding pregs BASE..BASE+DEPTH-1,
// with head at slot 0. Push and pop may happen in the same cycle.
module preg_free_fifo #(
  parameter int PAW   = 6,
  parameter int DEPTH = 32,
  parameter int BASE  = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic [PAW-1:0] push_data,
  input  logic           pop,
  output logic [PAW-1:0] head_data,
  output logic [PAW:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [PAW:0]  COUNT_FULL = (PAW+1)'(DEPTH);

  logic [PAW-1:0] mem_r [DEPTH];
  logic [PW-1:0]  head_r;
  logic [PW-1:0]  tail_r;
  logic [PAW:0]   count_r;

  // The list is full at reset, so tail starts equal to head and both pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= PAW'(BASE + i);
      end
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= COUNT_FULL;
    end else begin
      if (push) begin
        mem_r[tail_r] <= push_data;
        tail_r        <= tail_r + PTR_ONE;
      end
      if (pop) begin
        head_r <= head_r + PTR_ONE;
      end
      count_r <= count_r + {{PAW{1'b0}}, push} - {{PAW{1'b0}}, pop};
    end
  end

  assign head_data = mem_r[head_r];
  assign count     = count_r;

endmodule

// File: rtl/rename_alloc_ctrl.sv
// Allocates a physical destination register and an active-list slot for each renamed instruction.
// Retires entries at the head. On a flush it unwinds entries youngest-first from the tail.
module rename_alloc_ctrl
  import rename_alloc_ctrl_pkg::*;
#(
  parameter int PREG_ADDR_WIDTH = 6,
  parameter int FREE_LIST_WIDTH = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alloc_req,
  input  logic [VREG_WIDTH-1:0]       alloc_vreg,
  input  logic [PREG_ADDR_WIDTH-1:0]  alloc_old_preg,
  output logic                        alloc_grant,
  output logic [PREG_ADDR_WIDTH-1:0]  alloc_preg,
  output logic [FREE_LIST_WIDTH-1:0]  alloc_index,
  output logic                        stall_out,
  input  logic                        commit_valid,
  input  logic                        global_flush,
  output logic                        recover_valid,
  output logic [VREG_WIDTH-1:0]       recover_vreg,
  output logic [PREG_ADDR_WIDTH-1:0]  recover_old_preg,
  output logic                        busy,
  output logic [PREG_ADDR_WIDTH:0]    fl_count
);

  localparam int PAW      = PREG_ADDR_WIDTH;
  localparam int FLW      = FREE_LIST_WIDTH;
  localparam int FL_DEPTH = 2**PAW - ARCH_REGS;
  localparam int AL_DEPTH = 2**FLW;
  localparam logic [FLW:0]   AL_FULL  = {1'b1, {FLW{1'b0}}};
  localparam logic [FLW:0]   AL_LAST  = {{FLW{1'b0}}, 1'b1};
  localparam logic [FLW-1:0] AL_ONE   = {{(FLW-1){1'b0}}, 1'b1};

  rn_state_e             state_r;
  logic [FLW-1:0]        al_head_r;
  logic [FLW-1:0]        al_tail_r;
  logic [FLW:0]          al_count_r;
  logic [VREG_WIDTH-1:0] al_vreg_r [AL_DEPTH];
  logic [PAW-1:0]        al_old_r  [AL_DEPTH];
  logic [PAW-1:0]        al_new_r  [AL_DEPTH];

  logic [FLW-1:0] rec_idx_s;
  logic           grant_s;
  logic           commit_s;
  logic           recover_s;
  logic           push_s;
  logic [PAW-1:0] push_data_s;
  logic [PAW-1:0] head_preg_s;
  logic [PAW:0]   fl_count_s;

  preg_free_fifo #(
    .PAW   (PAW),
    .DEPTH (FL_DEPTH),
    .BASE  (ARCH_REGS)
  ) u_free_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (grant_s),
    .head_data (head_preg_s),
    .count     (fl_count_s)
  );

  // Grant uses registered counts, so a preg freed this cycle is not visible to this cycle's alloc.
  always_comb begin
    rec_idx_s = al_tail_r - AL_ONE;
    recover_s = (state_r == RN_RECOVER);
    grant_s   = (state_r == RN_RUN) && alloc_req && !global_flush &&
                (fl_count_s != '0) && (al_count_r != AL_FULL);
    commit_s  = (state_r == RN_RUN) && commit_valid && (al_count_r != '0);
    push_s    = commit_s || recover_s;
    if (recover_s) begin
      push_data_s = al_new_r[rec_idx_s];
    end else begin
      push_data_s = al_old_r[al_head_r];
    end
  end

  assign alloc_grant      = grant_s;
  assign alloc_preg       = head_preg_s;
  assign alloc_index      = al_tail_r;
  assign stall_out        = alloc_req && !grant_s;
  assign recover_valid    = recover_s;
  assign recover_vreg     = recover_s ? al_vreg_r[rec_idx_s] : '0;
  assign recover_old_preg = recover_s ? al_old_r[rec_idx_s] : '0;
  assign busy             = recover_s;
  assign fl_count         = fl_count_s;

  // Control FSM. In RECOVER it pops one entry per cycle from the tail until the list is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= RN_RUN;
      al_head_r  <= '0;
      al_tail_r  <= '0;
      al_count_r <= '0;
    end else begin
      case (state_r)
        RN_RUN: begin
          if (grant_s) begin
            al_tail_r <= al_tail_r + AL_ONE;
          end
          if (commit_s) begin
            al_head_r <= al_head_r + AL_ONE;
          end
          al_count_r <= al_count_r + {{FLW{1'b0}}, grant_s} - {{FLW{1'b0}}, commit_s};
          // A same-cycle commit retires first; only the entries left over are unwound.
          if (global_flush && (al_count_r != {{FLW{1'b0}}, commit_s})) begin
            state_r <= RN_RECOVER;
          end
        end
        RN_RECOVER: begin
          al_tail_r  <= rec_idx_s;
          al_count_r <= al_count_r - AL_LAST;
          if (al_count_r == AL_LAST) begin
            state_r <= RN_RUN;
          end
        end
        default: begin
          state_r <= RN_RUN;
        end
      endcase
    end
  end

  // Active-list payload is captured at the tail slot on each grant.
  always_ff @(posedge clk) begin
    if (grant_s) begin
      al_vreg_r[al_tail_r] <= alloc_vreg;
      al_old_r[al_tail_r]  <= alloc_old_preg;
      al_new_r[al_tail_r]  <= head_preg_s;
    end
  end

endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// Directed bench for rename_alloc_ctrl. It covers allocation, full stall, commit recycling,
// flush unwind and reset during recovery.
module tb_rename_alloc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alloc_req = 1'b0;
  logic [4:0] alloc_vreg = 5'd0;
  logic [5:0] alloc_old_preg = 6'd0;
  logic       alloc_grant;
  logic [5:0] alloc_preg;
  logic [2:0] alloc_index;
  logic       stall_out;
  logic       commit_valid = 1'b0;
  logic       global_flush = 1'b0;
  logic       recover_valid;
  logic [4:0] recover_vreg;
  logic [5:0] recover_old_preg;
  logic       busy;
  logic [6:0] fl_count;

  int   n_checks = 0;
  int   n_fails  = 0;
  int   m_fl;
  int   m_al;
  logic m_busy;
  logic exp_grant;

  rename_alloc_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alloc_req        (alloc_req),
    .alloc_vreg       (alloc_vreg),
    .alloc_old_preg   (alloc_old_preg),
    .alloc_grant      (alloc_grant),
    .alloc_preg       (alloc_preg),
    .alloc_index      (alloc_index),
    .stall_out        (stall_out),
    .commit_valid     (commit_valid),
    .global_flush     (global_flush),
    .recover_valid    (recover_valid),
    .recover_vreg     (recover_vreg),
    .recover_old_preg (recover_old_preg),
    .busy             (busy),
    .fl_count         (fl_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs mid-cycle and check the per-cycle outputs against the model
  task automatic drive(input logic req, input logic [4:0] vreg, input logic [5:0] old,
                       input logic cm, input logic fl);
    alloc_req      = req;
    alloc_vreg     = vreg;
    alloc_old_preg = old;
    commit_valid   = cm;
    global_flush   = fl;
    #2;
    exp_grant = !m_busy && req && !fl && (m_fl != 0) && (m_al != 8);
    check_eq("grant", 32'(alloc_grant), 32'(exp_grant));
    check_eq("stall", 32'(stall_out), 32'(req & ~exp_grant));
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("recover_valid", 32'(recover_valid), 32'(m_busy));
    check_eq("fl_count", 32'(fl_count), 32'(m_fl));
    if (!m_busy) check_eq("invariant", 32'(fl_count) + 32'(m_al), 32'd32);
  endtask

  task automatic tick();
    int g;
    int c;
    @(posedge clk);
    g = exp_grant ? 1 : 0;
    c = (commit_valid && (m_al != 0)) ? 1 : 0;
    if (m_busy) begin
      m_fl = m_fl + 1;
      m_al = m_al - 1;
      if (m_al == 0) m_busy = 1'b0;
    end else begin
      m_fl = m_fl - g + c;
      m_al = m_al + g - c;
      if (global_flush && (m_al != 0)) m_busy = 1'b1;
    end
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    alloc_req = 1'b0; alloc_vreg = 5'd0; alloc_old_preg = 6'd0;
    commit_valid = 1'b0; global_flush = 1'b0;
    m_fl = 32; m_al = 0; m_busy = 1'b0; exp_grant = 1'b0;
    #2;
    check_eq("rst_preg", 32'(alloc_preg), 32'd32);
    check_eq("rst_index", 32'(alloc_index), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_recover_valid", 32'(recover_valid), 32'd0);
    check_eq("rst_recover_vreg", 32'(recover_vreg), 32'd0);
    check_eq("rst_recover_old", 32'(recover_old_preg), 32'd0);
    check_eq("rst_fl_count", 32'(fl_count), 32'd32);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // 1: three grants from reset
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(i + 1), 6'(i + 1), 1'b0, 1'b0);
      check_eq("t1_preg", 32'(alloc_preg), 32'(32 + i));
      check_eq("t1_index", 32'(alloc_index), 32'(i));
      tick();
    end
    drive(1'b0, 5'd0, 6'd0, 1'b0, 1'b0);
    check_eq("t1_fl_count", 32'(fl_count), 32'd29);
    tick();

    // 2: active list full, then a commit frees a slot for the following cycle
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'(i), 6'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 5'd9, 6'd9, 1'b0, 1'b0);
    check_eq("t2_full_grant", 32'(alloc_grant), 32'd0);
    check_eq("t2_full_stall", 32'(stall_out), 32'd1);
    tick();
    drive(1'b1, 5'd9, 6'd9, 1'b1, 1'b0);
    check_eq("t2_commit_grant", 32'(alloc_grant), 32'd0);
    tick();
    drive(1'b1, 5'd9, 6'd9, 1'b0, 1'b0);
    check_eq("t2_wrap_grant", 32'(alloc_grant), 32'd1);
    check_eq("t2_wrap_index", 32'(alloc_index), 32'd0);
    check_eq("t2_wrap_preg", 32'(alloc_preg), 32'd40);
    tick();

    // 3: a committed old preg goes to the free-list tail and is reallocated after 31 more
    do_reset();
    drive(1'b1, 5'd5, 6'd5, 1'b0, 1'b0);
    check_eq("t3_first_preg", 32'(alloc_preg), 32'd32);
    tick();
    drive(1'b0, 5'd0, 6'd0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 31; i++) begin
      drive(1'b1, 5'(i), 6'(i), 1'b0, 1'b0);
      check_eq("t3_seq_preg", 32'(alloc_preg), 32'(33 + i));
      tick();
      drive(1'b0, 5'd0, 6'd0, 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 5'd7, 6'd7, 1'b0, 1'b0);
    check_eq("t3_recycled_preg", 32'(alloc_preg), 32'd5);
    tick();

    // 4: flush of three entries unwinds youngest-first; commits and allocs are ignored meanwhile
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 5'(i), 6'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 5'd0, 6'd0, 1'b0, 1'b1);
    tick();
    for (int i = 3; i >= 1; i--) begin
      drive(1'b1, 5'd0, 6'd0, 1'b1, 1'b0);
      check_eq("t4_recover_vreg", 32'(recover_vreg), 32'(i));
      check_eq("t4_recover_old", 32'(recover_old_preg), 32'(i));
      tick();
    end
    drive(1'b0, 5'd0, 6'd0, 1'b0, 1'b0);
    check_eq("t4_fl_count", 32'(fl_count), 32'd32);
    check_eq("t4_next_preg", 32'(alloc_preg), 32'd35);
    tick();

    // 5: commit and flush together retire entry0 and unwind only entry1
    do_reset();
    drive(1'b1, 5'd1, 6'd1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd2, 6'd2, 1'b0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 6'd0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 5'd0, 6'd0, 1'b0, 1'b0);
    check_eq("t5_recover_vreg", 32'(recover_vreg), 32'd2);
    check_eq("t5_recover_old", 32'(recover_old_preg), 32'd2);
    tick();
    drive(1'b0, 5'd0, 6'd0, 1'b0, 1'b0);
    check_eq("t5_busy_done", 32'(busy), 32'd0);
    check_eq("t5_next_preg", 32'(alloc_preg), 32'd34);
    tick();

    // 6: reset asserted mid-recovery takes effect immediately
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 5'(i), 6'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 5'd0, 6'd0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 6'd0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_recover_valid", 32'(recover_valid), 32'd0);
    check_eq("t6_fl_count", 32'(fl_count), 32'd32);
    check_eq("t6_preg", 32'(alloc_preg), 32'd32);
    check_eq("t6_index", 32'(alloc_index), 32'd0);
    do_reset();
    drive(1'b1, 5'd4, 6'd4, 1'b0, 1'b0);
    check_eq("t6_after_preg", 32'(alloc_preg), 32'd32);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
